sipo_deframer: RTL
==================

# sipo_deframer

Serial-to-parallel receiver that sits directly downstream of the 4-bit PISO serializer and reassembles its MSB-first bit stream into parallel words. A start strobe marks the first data bit, and an optional even-parity bit follows the data. Completed words are held in a one-entry output register with a valid/ready handshake. Overrun and framing errors are flagged rather than silently absorbed.

## Interface
- n, 4: data word width in bits (n ≥ 2)
- PARITY_EN, 0: 1 = one even-parity bit follows the n data bits; 0 = no parity bit
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  high in the cycle the first (MSB) data bit is on i_serial_in
- i_serial_in  in  1  serial data, MSB first, one bit per cycle
- i_ready  in  1  consumer accepts o_parallel_out when high with o_valid
- o_parallel_out  out  n  assembled word, stable while o_valid high
- o_valid  out  1  output word available
- o_parity_err  out  1  parity of the held word failed; qualified by o_valid
- o_overrun  out  1  sticky: a completed word was dropped because the buffer was full
- o_frame_err  out  1  one-cycle pulse: i_start arrived mid-frame

## Operation
- Reset values: o_parallel_out = 0, o_valid = 0, o_parity_err = 0, o_overrun = 0, o_frame_err = 0, FSM = IDLE, bit counter = 0, shift register = 0.
- FSM states: IDLE, SHIFT, PARITY (only reachable when PARITY_EN = 1).
- IDLE:
  - i_start = 1: sample i_serial_in into shift-register LSB, set counter = 1, go to SHIFT.
  - Otherwise: i_serial_in is ignored.
- SHIFT:
  - Each cycle: shift left, insert i_serial_in at the LSB, increment counter.
  - When counter reaches n-1 (the last data bit is sampled in this cycle): go to PARITY if PARITY_EN = 1; otherwise complete the word and go to IDLE.
- PARITY: sample the parity bit. Error = XOR of the n data bits and the parity bit, which must equal 0. Complete the word and go to IDLE.
- Completion:
  - If the buffer is empty, or drains in the same cycle (o_valid & i_ready), load the word and its parity error, and set o_valid.
  - Otherwise drop the word and set o_overrun, which stays set until reset.
- Restart: i_start while in SHIFT or PARITY abandons the partial word, pulses o_frame_err for one cycle, and treats the current bit as MSB of a new frame (counter = 1, state SHIFT).
- Back-to-back frames: i_start in the cycle after completion is accepted normally from IDLE.
- Handshake:
  - o_valid stays high until o_valid & i_ready.
  - o_parallel_out and o_parity_err do not change while o_valid is high, except on a same-cycle drain-and-reload.
  - i_ready with o_valid low has no effect.

## Timing
- Frame length: n cycles (PARITY_EN = 0) or n+1 cycles (PARITY_EN = 1), counted from the i_start cycle.
- Latency: o_valid rises on the clock edge that samples the final frame bit, so it is visible in the cycle after that bit.
- Throughput: one word per frame length when i_ready is held high; no idle cycle is required between frames.
- Reset asserted mid-frame: all state clears immediately (asynchronously) and the partial word is discarded. After reset deassertion, the block waits in IDLE for i_start.

## Structure
- Package sipo_pkg:
  - state enum {IDLE, SHIFT, PARITY}
  - localparam CNT_W = $clog2(n+1)
- Sub-module sipo_out_buf: one-entry output register with valid/ready, load-when-empty-or-draining, and overrun flag generation. The deframer FSM, counter and shift register stay in sipo_deframer.

## Test plan
- n=4, PARITY_EN=0, i_ready=1: i_start with serial 1,0,1,0 → o_parallel_out = 4'b1010; o_valid high for exactly one cycle, in the cycle after the 4th bit.
- PARITY_EN=1: frame 1,0,1,1 followed by parity 1 → 4'b1011 with o_parity_err = 0. Same data with parity 0 → o_parity_err = 1.
- i_ready=0: two complete frames, 4'b1010 then 4'b0101 → output holds 4'b1010 and o_overrun goes high. After i_ready=1, one transfer of 4'b1010 occurs and o_overrun stays high.
- Second frame completes in the same cycle i_ready drains the first → no overrun; second word is presented in the next cycle.
- i_start reasserted at bit 2 of a frame → one-cycle o_frame_err pulse; the restarted frame 1,1,0,0 yields 4'b1100.
- i_rst asserted after 2 bits, then a full 4'b0110 frame → o_valid stays low until the new frame completes; output = 4'b0110.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deframer.
//   state_t     : deframer FSM encoding (IDLE, SHIFT, PARITY)
//   even_parity : parity check over a data word plus its received parity bit
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Returns 1 when data plus parity bit does not have even parity.
  function automatic logic even_parity_err(input logic [31:0] data, input int unsigned width,
                                           input logic par_bit);
    logic acc;
    acc = par_bit;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) acc = acc ^ data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry output register with valid/ready handshake.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_load           : a completed word is offered this cycle
//   i_word, i_perr   : offered word and its parity-error flag
//   i_ready          : consumer accepts the held word when high with o_valid
//   o_word, o_perr   : held word and its parity-error flag
//   o_valid          : held word is available
//   o_overrun        : sticky, a word was offered while the buffer stayed full
module sipo_out_buf #(
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_perr,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_word,
  output logic              o_perr,
  output logic              o_valid,
  output logic              o_overrun
);

  logic drain;
  logic accept;

  assign drain  = o_valid & i_ready;
  // The slot is usable if empty or emptied in this very cycle.
  assign accept = i_load & (~o_valid | i_ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_word    <= '0;
      o_perr    <= 1'b0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (accept) begin
        o_word  <= i_word;
        o_perr  <= i_perr;
        o_valid <= 1'b1;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
      if (i_load && !accept) o_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer for an MSB-first bit stream.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_start         : first (MSB) data bit is on i_serial_in this cycle
//   i_serial_in     : serial data, one bit per cycle
//   i_ready         : consumer accepts o_parallel_out when high with o_valid
//   o_parallel_out  : assembled word, stable while o_valid is high
//   o_valid         : output word available
//   o_parity_err    : parity of the held word failed (qualified by o_valid)
//   o_overrun       : sticky, a completed word was dropped (buffer full)
//   o_frame_err     : one-cycle pulse, i_start arrived mid-frame
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int n         = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_serial_in,
  input  logic         i_ready,
  output logic [n-1:0] o_parallel_out,
  output logic         o_valid,
  output logic         o_parity_err,
  output logic         o_overrun,
  output logic         o_frame_err
);

  localparam int CNT_W = $clog2(n + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(n - 1);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [n-1:0]   shreg;

  logic [n-1:0]   shifted;
  logic           complete;
  logic [n-1:0]   done_word;
  logic           done_perr;

  assign shifted = {shreg[n-2:0], i_serial_in};

  // A frame completes on its last data bit (no parity) or on the parity bit.
  // A restart strobe on that same cycle wins and abandons the word.
  always_comb begin
    complete  = 1'b0;
    done_word = shifted;
    done_perr = 1'b0;
    if (!i_start) begin
      if (state == SHIFT && cnt == LAST_CNT && !PARITY_EN) begin
        complete = 1'b1;
      end else if (state == PARITY) begin
        complete  = 1'b1;
        done_word = shreg;
        done_perr = even_parity_err(32'(shreg), n, i_serial_in);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= i_start && (state != IDLE);
      if (i_start) begin
        // New frame from IDLE, or restart mid-frame: current bit is the MSB.
        shreg <= {{(n-1){1'b0}}, i_serial_in};
        cnt   <= CNT_W'(1);
        state <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            shreg <= shifted;
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= PARITY_EN ? PARITY : IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            cnt   <= '0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  sipo_out_buf #(
    .DATA_W (n)
  ) u_out_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (complete),
    .i_word    (done_word),
    .i_perr    (done_perr),
    .i_ready   (i_ready),
    .o_word    (o_parallel_out),
    .o_perr    (o_parity_err),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

endmodule
